// File: rtl/muldiv_seq_pkg.sv
// Shared CPU package: ALU funct/aluconf constants plus the HI/LO
// multiply/divide unit's funct codes, FSM state type and iteration count.
package muldiv_seq_pkg;

    // ALU R-type funct codes
    localparam logic [5:0] FUNCT_ADDU  = 6'h21;
    localparam logic [5:0] FUNCT_SUBU  = 6'h23;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;

    // ALU operation select
    typedef enum logic [2:0] {
        ALUCONF_ADD,
        ALUCONF_SUB,
        ALUCONF_AND,
        ALUCONF_OR,
        ALUCONF_SLT
    } aluconf_t;

    // HI/LO unit funct codes
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    localparam int unsigned MULDIV_ITERS = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } muldiv_state_t;

    // Magnitude of v when treated as signed (sgn=1); v unchanged otherwise.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_seq_step.sv
// muldiv_step: one combinational radix-2 iteration.
//   is_div   : 1 = restoring divide step, 0 = shift-add multiply step
//   acc      : multiply -> {partial_hi, multiplier}, divide -> {remainder, dividend/quotient}
//   opnd     : multiplicand (multiply) or divisor (divide)
//   acc_next : accumulator after this iteration
module muldiv_step (
    input  logic        is_div,
    input  logic [63:0] acc,
    input  logic [31:0] opnd,
    output logic [63:0] acc_next
);

    logic [32:0] sum;
    logic [32:0] shifted;
    logic [32:0] diff;

    always_comb begin
        sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        // Remainder shifted left with the next dividend bit brought in.
        shifted  = acc[63:31];
        diff     = shifted - {1'b0, opnd};
        acc_next = '0;
        if (is_div) begin
            // Remainder stays below the divisor, so the restored value fits 32 bits.
            if (!diff[32])
                acc_next = {diff[31:0], acc[30:0], 1'b1};
            else
                acc_next = {shifted[31:0], acc[30:0], 1'b0};
        end else begin
            acc_next = {sum, acc[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential MIPS HI/LO multiply/divide unit.
// Build option: define MULDIV_FAST_MUL_EN to compute MULT/MULTU with a single
// full 32x32 multiply in one RUN cycle (division stays iterative).
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : operation in i_funct is valid this cycle
//   i_funct        : MIPS funct code (MULT/MULTU/DIV/DIVU/MFHI/MTHI/MFLO/MTLO)
//   i_a, i_b       : rs / rt operands
//   i_flush        : abort the in-flight operation
//   o_busy         : HI/LO not yet valid
//   o_done         : one-cycle pulse when a mul/div updates HI/LO
//   o_hi, o_lo     : architectural HI/LO
//   o_rdata        : HI for MFHI, LO for MFLO, else 0
module muldiv_seq
    import muldiv_seq_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [5:0]  i_funct,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_flush,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic [31:0] o_rdata
);

    muldiv_state_t state, state_nxt;

    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [63:0] acc_step;
    logic [31:0] opnd;
    logic        is_div;
    logic        neg_res;
    logic        neg_rem;
    logic        div_zero;
    logic [31:0] hi, lo;

    logic        accept;
    logic        is_md_funct;
    logic        is_div_funct;
    logic        is_signed_funct;
    logic        sign_a, sign_b;
    logic        last_iter;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    assign accept          = (state == ST_IDLE) && i_start && !i_flush;
    assign is_md_funct     = (i_funct == FUNCT_MULT) || (i_funct == FUNCT_MULTU) ||
                             (i_funct == FUNCT_DIV)  || (i_funct == FUNCT_DIVU);
    assign is_div_funct    = (i_funct == FUNCT_DIV)  || (i_funct == FUNCT_DIVU);
    assign is_signed_funct = (i_funct == FUNCT_MULT) || (i_funct == FUNCT_DIV);
    assign sign_a          = is_signed_funct && i_a[31];
    assign sign_b          = is_signed_funct && i_b[31];

`ifdef MULDIV_FAST_MUL_EN
    assign last_iter = !is_div || (cnt == 5'(MULDIV_ITERS - 1));
`else
    assign last_iter = (cnt == 5'(MULDIV_ITERS - 1));
`endif

    muldiv_step u_step (
        .is_div   (is_div),
        .acc      (acc),
        .opnd     (opnd),
        .acc_next (acc_step)
    );

    // Sign correction applied in FIX.
    always_comb begin
        prod_fix = neg_res ? (~acc + 64'd1) : acc;
        quo_fix  = neg_res ? (~acc[31:0] + 32'd1) : acc[31:0];
        rem_fix  = neg_rem ? (~acc[63:32] + 32'd1) : acc[63:32];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        o_busy    = (state != ST_IDLE);
        o_done    = (state == ST_DONE);
        case (state)
            ST_IDLE: if (accept && is_md_funct) state_nxt = ST_RUN;
            ST_RUN: begin
                if (i_flush)        state_nxt = ST_IDLE;
                else if (last_iter) state_nxt = ST_FIX;
            end
            ST_FIX:  state_nxt = i_flush ? ST_IDLE : ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && is_md_funct) begin
                        // Multiply: opnd=|a| multiplicand, acc lo=|b| multiplier.
                        // Divide:   opnd=|b| divisor,      acc lo=|a| dividend.
                        cnt      <= '0;
                        is_div   <= is_div_funct;
                        neg_res  <= sign_a ^ sign_b;
                        neg_rem  <= sign_a;
                        div_zero <= (i_b == '0);
                        if (is_div_funct) begin
                            opnd <= abs32(i_b, sign_b);
                            acc  <= {32'd0, abs32(i_a, sign_a)};
                        end else begin
                            opnd <= abs32(i_a, sign_a);
                            acc  <= {32'd0, abs32(i_b, sign_b)};
                        end
                    end else if (accept && i_funct == FUNCT_MTHI) begin
                        hi <= i_a;
                    end else if (accept && i_funct == FUNCT_MTLO) begin
                        lo <= i_a;
                    end
                end
                ST_RUN: begin
                    if (!i_flush) begin
                        cnt <= cnt + 5'd1;
`ifdef MULDIV_FAST_MUL_EN
                        if (is_div)
                            acc <= acc_step;
                        else
                            acc <= {32'd0, opnd} * {32'd0, acc[31:0]};
`else
                        acc <= acc_step;
`endif
                    end
                end
                ST_FIX: begin
                    if (!i_flush) begin
                        if (is_div) begin
                            // With a zero divisor every trial subtract succeeds, leaving
                            // |a| as remainder; sign fix restores i_a, LO is forced to all ones.
                            lo <= div_zero ? '1 : quo_fix;
                            hi <= rem_fix;
                        end else begin
                            hi <= prod_fix[63:32];
                            lo <= prod_fix[31:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (i_funct)
            FUNCT_MFHI: o_rdata = hi;
            FUNCT_MFLO: o_rdata = lo;
            default:    o_rdata = '0;
        endcase
    end

    assign o_hi = hi;
    assign o_lo = lo;

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset, listed first: i_clk input 1 (rising-edge clock); i_rst_n input 1 (asynchronous active-low reset).
REQ-002 SHALL have i_start input 1: the operation in i_funct is valid this cycle.
REQ-003 SHALL have i_funct input 6: MIPS funct code (MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13).
REQ-004 SHALL have i_a input 32 (rs: multiplicand/dividend/MT source) and i_b input 32 (rt: multiplier/divisor).
REQ-005 SHALL have i_flush input 1: abort the in-flight operation (pipeline flush).
REQ-006 SHALL have o_busy output 1: HI/LO not yet valid; the pipeline stalls any MF/MT/mul/div while this is high.
REQ-007 SHALL have o_done output 1: one-cycle pulse when HI/LO are updated by a mul/div.
REQ-008 SHALL have o_hi output 32 and o_lo output 32: architectural HI/LO registers.
REQ-009 SHALL have o_rdata output 32: combinational HI for MFHI, LO for MFLO, else 0.

Function
REQ-010 SHALL implement the FSM states IDLE, RUN, FIX, DONE; o_busy = (state != IDLE).
REQ-011 SHALL accept a start only in IDLE with i_start=1 and i_flush=0; a start in any other state is ignored.
REQ-012 SHALL, on accepting MULT/MULTU/DIV/DIVU, latch the operands (absolute values when signed), record the sign flags, clear the 5-bit iteration counter, and go to RUN.
REQ-013 SHALL perform one radix-2 step per RUN cycle (shift-add multiply or restoring divide) for exactly 32 cycles, then go to FIX.
REQ-014 SHALL, in FIX, apply sign correction: product negated if the operand signs differ; quotient negated if the signs differ; remainder takes the dividend's sign.
REQ-015 SHALL write HI/LO on the FIX->DONE edge, assert o_done for the single DONE cycle, and then return to IDLE.
REQ-016 SHALL meet the latency: start accepted at cycle 0, RUN cycles 1-32, FIX cycle 33, o_done and new HI/LO at cycle 34, IDLE at cycle 35.
REQ-017 SHALL place the product in HI (upper 32 bits) and LO (lower 32 bits); for division, LO = quotient and HI = remainder.
REQ-018 SHALL handle divide by zero (signed or unsigned) as LO=0xFFFFFFFF, HI=dividend (i_a), with normal latency.
REQ-019 SHALL handle signed 0x80000000 / 0xFFFFFFFF as LO=0x80000000, HI=0.
REQ-020 SHALL, for MTHI/MTLO accepted in IDLE, write i_a to HI/LO on the next edge, keep the state in IDLE, and not assert o_done.
REQ-021 SHALL treat MFHI/MFLO as having no state effect.
REQ-022 SHALL treat unknown funct codes with i_start=1 as no-ops.
REQ-023 SHALL, on i_flush=1 in RUN or FIX, return to IDLE next cycle with HI/LO unchanged and no o_done.
REQ-024 SHALL let a flush in DONE complete normally, because HI/LO are already committed.
REQ-025 SHALL, on i_flush and i_start together in IDLE, let the flush win and accept nothing.

Reset
REQ-026 SHALL, while i_rst_n=0, force: state=IDLE, HI=0, LO=0, counter=0, o_done=0, o_busy=0.
REQ-027 SHALL, on reset mid-operation, discard the partial result, leaving HI/LO at 0.

Configuration
REQ-028 SHALL, with MULDIV_FAST_MUL_EN defined, compute MULT/MULTU in a single RUN cycle using a full 32x32 multiplier: o_done at cycle 3 after start (RUN 1, FIX 2, DONE 3); division is unchanged.
REQ-029 SHALL, without MULDIV_FAST_MUL_EN, use the 32-cycle iterative multiply of REQ-013.

Structure
REQ-030 SHALL place the funct code constants, the FSM state enumeration, and the iteration count (32) in the shared CPU package, next to the ALU funct/aluconf constants.
REQ-031 SHALL use one sub-module, muldiv_step: a combinational single-iteration shift-add/restoring-subtract cell; muldiv_seq holds the FSM, counter, operand registers, and HI/LO.

Verification
REQ-032 SHALL cover: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> o_done at cycle 34, HI=0xFFFFFFFE, LO=0x00000001, o_busy high cycles 1-34.
REQ-033 SHALL cover: MULT -3 x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-034 SHALL cover: DIVU 0x1234 / 0 -> LO=0xFFFFFFFF, HI=0x00001234; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-035 SHALL cover: MTHI 0xDEADBEEF in IDLE -> HI=0xDEADBEEF next cycle, no o_done; a second i_start (MTLO) while busy -> ignored, LO unchanged.
REQ-036 SHALL cover: DIV started, then i_flush at cycle 10 -> IDLE at cycle 11, HI/LO keep prior values, no o_done; i_rst_n low at cycle 20 of a MULT -> HI=LO=0, o_busy=0 immediately.
REQ-037 SHALL cover: with MULDIV_FAST_MUL_EN, MULT 7 x -2 -> o_done at cycle 3, HI=0xFFFFFFFF, LO=0xFFFFFFF2.
